// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with operand/result valid-ready handshakes and Z/C/N/V flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 011.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             negative_flag,
    output logic             overflow_flag,
    output logic             busy
);
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r, state_next_s;
    logic               in_ready_r, busy_r, out_valid_r;
    logic               in_ready_s, busy_s, out_valid_s;
    logic [2:0]         op_r;
    logic [2*WIDTH-1:0] acc_r, step_s;
    logic [CW-1:0]      cnt_r;
    logic               accept_s, multi_s, last_step_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   sc_result_s, ex_result_s, load_result_s;
    logic               sc_carry_s, sc_ovf_s, ex_carry_s;
    logic               load_en_s, load_carry_s, load_ovf_s;
    logic [WIDTH-1:0]   alu_result_r;
    logic               zero_r, carry_r, negative_r, overflow_r;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH:0]     mul_sum_s;
`endif

    // in_ready is a flop, so an accept never depends combinationally on itself
    assign accept_s    = in_valid & in_ready_r;
    assign last_step_s = (cnt_r == CNT_ONE);

    // Single-cycle datapath evaluated directly on the incoming operands
    always_comb begin
        sum_s       = {(WIDTH+1){1'b0}};
        sc_result_s = {WIDTH{1'b0}};
        sc_carry_s  = 1'b0;
        sc_ovf_s    = 1'b0;
        case (alu_op)
            OP_AND:  sc_result_s = a_in & b_in;
            OP_OR:   sc_result_s = a_in | b_in;
            OP_ADD: begin
                sum_s       = {1'b0, a_in} + {1'b0, b_in};
                sc_result_s = sum_s[WIDTH-1:0];
                sc_carry_s  = sum_s[WIDTH];
                sc_ovf_s    = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum_s[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                sum_s       = {1'b0, a_in} + {1'b0, ~b_in} + {{WIDTH{1'b0}}, 1'b1};
                sc_result_s = sum_s[WIDTH-1:0];
                sc_carry_s  = sum_s[WIDTH];
                sc_ovf_s    = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sum_s[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SHL:  sc_result_s = a_in;
            OP_SHR:  sc_result_s = a_in;
            OP_PASS: sc_result_s = b_in;
            default: sc_result_s = {WIDTH{1'b0}};
        endcase
    end

    // Decide whether the accepted operation needs the iterative engine
    always_comb begin
        multi_s = 1'b0;
        if ((alu_op == OP_SHL) || (alu_op == OP_SHR)) begin
            multi_s = (b_in[SHW-1:0] != {SHW{1'b0}});
        end
`ifdef ALU_MUL_EN
        else if (alu_op == OP_MUL) begin
            multi_s = 1'b1;
        end
`endif
        else begin
            multi_s = 1'b0;
        end
    end

    // One iteration step: single-bit shift, or LSB-first shift-add into the upper half
    always_comb begin
        step_s     = acc_r;
        ex_carry_s = 1'b0;
`ifdef ALU_MUL_EN
        mul_sum_s  = {(WIDTH+1){1'b0}};
`endif
        case (op_r)
            OP_SHL: begin
                step_s     = {{WIDTH{1'b0}}, acc_r[WIDTH-2:0], 1'b0};
                ex_carry_s = acc_r[WIDTH-1];
            end
            OP_SHR: begin
                step_s     = {{WIDTH{1'b0}}, 1'b0, acc_r[WIDTH-1:1]};
                ex_carry_s = acc_r[0];
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
                step_s     = {mul_sum_s, acc_r[WIDTH-1:1]};
                ex_carry_s = |step_s[2*WIDTH-1:WIDTH];
            end
`endif
            default: begin
                step_s     = acc_r;
                ex_carry_s = 1'b0;
            end
        endcase
        ex_result_s = step_s[WIDTH-1:0];
    end

    // Select what gets captured into the result/flag registers on entry to DONE
    always_comb begin
        load_en_s     = 1'b0;
        load_result_s = sc_result_s;
        load_carry_s  = sc_carry_s;
        load_ovf_s    = sc_ovf_s;
        if (accept_s && !multi_s) begin
            load_en_s = 1'b1;
        end else if ((state_r == ST_EXEC) && last_step_s) begin
            load_en_s     = 1'b1;
            load_result_s = ex_result_s;
            load_carry_s  = ex_carry_s;
            load_ovf_s    = 1'b0;
        end else begin
            load_en_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = multi_s ? ST_EXEC : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (last_step_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake/status decode from the next state, captured into flops below
    always_comb begin
        in_ready_s  = (state_next_s == ST_IDLE);
        busy_s      = (state_next_s == ST_EXEC) || (state_next_s == ST_DONE);
        out_valid_s = (state_next_s == ST_DONE);
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Operand capture and iteration state
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= OP_AND;
            acc_r <= {(2*WIDTH){1'b0}};
            cnt_r <= {CW{1'b0}};
`ifdef ALU_MUL_EN
            a_r   <= {WIDTH{1'b0}};
`endif
        end else if (accept_s) begin
            op_r  <= alu_op;
            cnt_r <= {1'b0, b_in[SHW-1:0]};
            acc_r <= {{WIDTH{1'b0}}, a_in};
`ifdef ALU_MUL_EN
            a_r   <= a_in;
            if (alu_op == OP_MUL) begin
                acc_r <= {{WIDTH{1'b0}}, b_in};
                cnt_r <= CNT_MUL;
            end
`endif
        end else if (state_r == ST_EXEC) begin
            acc_r <= step_s;
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Result and flag registers; held bit-stable until the next operation completes
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_r <= {WIDTH{1'b0}};
            zero_r       <= 1'b0;
            carry_r      <= 1'b0;
            negative_r   <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (load_en_s) begin
            alu_result_r <= load_result_s;
            zero_r       <= (load_result_s == {WIDTH{1'b0}});
            carry_r      <= load_carry_s;
            negative_r   <= load_result_s[WIDTH-1];
            overflow_r   <= load_ovf_s;
        end else begin
            alu_result_r <= alu_result_r;
        end
    end

    assign in_ready      = in_ready_r;
    assign busy          = busy_r;
    assign out_valid     = out_valid_r;
    assign alu_result    = alu_result_r;
    assign zero_flag     = zero_r;
    assign carry_flag    = carry_r;
    assign negative_flag = negative_r;
    assign overflow_flag = overflow_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, handshake/reset corner sequences and randomized ops
// checked against an arithmetic reference model (WIDTH=8).
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a_in = 8'h00;
    logic [W-1:0] b_in = 8'h00;
    logic [2:0]   alu_op = 3'd0;
    logic         in_ready, out_valid, busy;
    logic         zero_flag, carry_flag, negative_flag, overflow_flag;
    logic [W-1:0] alu_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .negative_flag(negative_flag),
        .overflow_flag(overflow_flag), .busy(busy)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        int         lat;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode definitions
    function automatic void model(input logic [2:0] op, input int a, input int b,
                                  output int res, output int c, output int v, output int lat);
        int s, p, sa, sb, r;
        s   = b % W;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        res = 0; c = 0; v = 0; lat = 1; r = 0;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: begin
                p = a + b; res = p % 256; c = (p > 255) ? 1 : 0;
                r = sa + sb; v = (r > 127 || r < -128) ? 1 : 0;
            end
            3'd3: begin
`ifdef ALU_MUL_EN
                p = a * b; res = p % 256; c = (p > 255) ? 1 : 0; lat = W + 1;
`else
                res = 0;
`endif
            end
            3'd4: begin
                res = (a << s) % 256; c = (s > 0) ? ((a >> (W - s)) & 1) : 0; lat = 1 + s;
            end
            3'd5: begin
                res = a >> s; c = (s > 0) ? ((a >> (s - 1)) & 1) : 0; lat = 1 + s;
            end
            3'd6: begin
                p = a - b; res = (p + 256) % 256; c = (a >= b) ? 1 : 0;
                r = sa - sb; v = (r > 127 || r < -128) ? 1 : 0;
            end
            default: res = b;
        endcase
    endfunction

    task automatic do_accept(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        alu_op = op; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); alu_op = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) check("valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] res, input logic c,
                           input logic z, input logic n, input logic v, input int lat,
                           input int stall);
        int got_lat;
        do_accept(op, a, b);
        wait_valid(got_lat);
        check({tag, ".lat"}, got_lat, lat);
        check({tag, ".res"}, alu_result, res);
        check({tag, ".flags"}, {zero_flag, carry_flag, negative_flag, overflow_flag}, {z, c, n, v});
        repeat (stall) begin @(posedge clk); #1; end
        check({tag, ".held"}, {out_valid, alu_result, zero_flag, carry_flag, negative_flag, overflow_flag},
              {1'b1, res, z, c, n, v});
        handshake();
        check({tag, ".rdy_after"}, {in_ready, busy, out_valid}, 3'b100);
    endtask

    initial begin
        int lat, res, c, v, seen;
        logic [2:0] op;
        logic [7:0] a, b, r8;

        vt.push_back('{3'd2, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1});
        vt.push_back('{3'd6, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{3'd6, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1});
        vt.push_back('{3'd6, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{3'd4, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 4});
        vt.push_back('{3'd5, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2});
        vt.push_back('{3'd4, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{3'd5, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8});
        vt.push_back('{3'd4, 8'h01, 8'hF9, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 2});
        vt.push_back('{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{3'd7, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1});
`ifdef ALU_MUL_EN
        vt.push_back('{3'd3, 8'h12, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 9});
`else
        vt.push_back('{3'd3, 8'h12, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1});
`endif

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("reset_outs", {in_ready, out_valid, busy, alu_result, zero_flag, carry_flag,
              negative_flag, overflow_flag}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_rdy", {in_ready, busy, out_valid}, 3'b100);

        for (int i = 0; i < vt.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].res,
                    vt[i].c, vt[i].z, vt[i].n, vt[i].v, vt[i].lat, 0);
        end

        // Backpressure: hold the result for 5 cycles
        do_accept(3'd2, 8'h10, 8'h20);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {out_valid, in_ready, busy, alu_result, zero_flag, carry_flag,
                  negative_flag, overflow_flag}, {1'b1, 1'b0, 1'b1, 8'h30, 4'b0000});
            @(posedge clk); #1;
        end
        handshake();
        check("bp_release", {in_ready, busy, out_valid}, 3'b100);

        // Reset in the 3rd EXEC cycle aborts the operation
`ifdef ALU_MUL_EN
        do_accept(3'd3, 8'h12, 8'h10);
`else
        do_accept(3'd4, 8'h81, 8'h07);
`endif
        check("rm_busy", {busy, in_ready, out_valid}, 3'b100);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rm_rst_outs", {in_ready, out_valid, busy, alu_result, zero_flag, carry_flag,
              negative_flag, overflow_flag}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rm_rdy", in_ready, 1'b1);
        seen = 0;
        repeat (12) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        check("rm_no_valid", seen, 0);
        run_vec("rm_add", 3'd2, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            model(op, int'(a), int'(b), res, c, v, lat);
            r8 = res[7:0];
            run_vec($sformatf("rand%0d_op%0d", i, op), op, a, b, r8, c[0], (r8 == 8'h00),
                    r8[7], v[0], lat, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
